// File: rtl/vec_chunk_buffer_if.sv
// vec_chunk_buffer_if
//   Bundles the write-element stream and the chunk-read port of
//   vec_chunk_buffer.
//   slave  : the buffer itself.
//   master : the upstream producer and downstream consumer, seen as one side.
//   Write side : wr_valid/wr_data in, wr_ready out, ovf_err (sticky) out.
//   Read side  : rd_chunk_req/rd_ptr_rst/rd_release in, rd_ready/rd_data out.
//   Chunk must match the Chunk parameter of the attached buffer.
interface vec_chunk_buffer_if #(
  parameter int Chunk = 4
);
  logic                   wr_valid;
  logic signed [7:0]      wr_data;
  logic                   wr_ready;
  logic                   rd_ready;
  logic [Chunk-1:0][7:0]  rd_data;
  logic                   rd_chunk_req;
  logic                   rd_ptr_rst;
  logic                   rd_release;
  logic                   ovf_err;

  modport slave (
    input  wr_valid, wr_data, rd_chunk_req, rd_ptr_rst, rd_release,
    output wr_ready, rd_ready, rd_data, ovf_err
  );

  modport master (
    output wr_valid, wr_data, rd_chunk_req, rd_ptr_rst, rd_release,
    input  wr_ready, rd_ready, rd_data, ovf_err
  );
endinterface

// File: rtl/vec_chunk_buffer.sv
// vec_chunk_buffer
//   Double-buffered activation vector store between two matrix-vector layers.
//   One signed 8-bit element is written per cycle into the fill bank while the
//   downstream layer reads fixed-width chunks from the other bank.
//   Ports:
//     clk_in : clock, rising edge
//     rst_in : asynchronous active-high reset
//     bus    : vec_chunk_buffer_if.slave (write stream + chunk read port)
//   Parameters:
//     VecLength : elements per vector (multiple of Chunk)
//     Chunk     : elements per read chunk

// vcb_lane
//   One read lane: picks element rd_ptr*Chunk+Lane out of the read bank.
//   Ports: bank_vec (whole read bank), rd_ptr (chunk index), elem (lane out).
module vcb_lane #(
  parameter int VecLength = 8,
  parameter int Chunk     = 4,
  parameter int Lane      = 0,
  parameter int PtrW      = 1
) (
  input  logic [VecLength-1:0][7:0] bank_vec,
  input  logic [PtrW-1:0]           rd_ptr,
  output logic [7:0]                elem
);
  localparam int NumChunks = VecLength / Chunk;

  // Explicit mux over chunk indices keeps index widths exact.
  always_comb begin
    elem = '0;
    for (int c = 0; c < NumChunks; c++) begin
      if (rd_ptr == c[PtrW-1:0]) elem = bank_vec[c*Chunk+Lane];
    end
  end
endmodule

module vec_chunk_buffer #(
  parameter int VecLength = 8,
  parameter int Chunk     = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  vec_chunk_buffer_if.slave  bus
);
  localparam int NumChunks = VecLength / Chunk;
  localparam int PtrW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int CntW      = (VecLength > 1) ? $clog2(VecLength) : 1;

  logic [1:0][VecLength-1:0][7:0] mem;
  logic [1:0]                     full;
  logic [1:0]                     full_nxt;
  logic                           wb;
  logic                           rb;
  logic [CntW-1:0]                wcnt;
  logic [PtrW-1:0]                rd_ptr;
  logic                           ovf;

  logic                           wr_ready;
  logic                           accept;
  logic                           wr_last;
  logic                           rel_ok;
  logic [VecLength-1:0][7:0]      rd_bank;
  logic [Chunk-1:0][7:0]          rd_chunk;

  // ---------------------------------------------------------------- control
  assign wr_ready = ~(full[0] & full[1]);
  assign accept   = bus.wr_valid & wr_ready;
  assign wr_last  = accept & (wcnt == CntW'(VecLength-1));
  // A release is meaningful only against a full read bank.
  assign rel_ok   = bus.rd_release & full[rb];

  // Release clears rb, completion sets wb. When both fire they always hit
  // different banks (wb can only be written while empty), so apply both.
  always_comb begin
    full_nxt = full;
    if (rel_ok)  full_nxt[rb] = 1'b0;
    if (wr_last) full_nxt[wb] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wcnt   <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      full <= full_nxt;

      if (accept) begin
        if (wr_last) begin
          wcnt <= '0;
          wb   <= ~wb;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      // Dropped element: no state change other than the sticky flag.
      if (bus.wr_valid & ~wr_ready) ovf <= 1'b1;

      // Read pointer priority: release > rewind > advance.
      if (rel_ok) begin
        rb     <= ~rb;
        rd_ptr <= '0;
      end else if (bus.rd_ptr_rst) begin
        rd_ptr <= '0;
      end else if (bus.rd_chunk_req) begin
        rd_ptr <= (rd_ptr == PtrW'(NumChunks-1)) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- storage
  // Zeroed on reset so rd_data reads 0 until something is written.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem <= '0;
    end else if (accept) begin
      mem[wb][wcnt] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------- read mux
  // rd_data follows the read bank regardless of its full flag; consumers
  // qualify it with rd_ready.
  assign rd_bank = mem[rb];

  for (genvar i = 0; i < Chunk; i++) begin : g_lane
    vcb_lane #(
      .VecLength (VecLength),
      .Chunk     (Chunk),
      .Lane      (i),
      .PtrW      (PtrW)
    ) u_lane (
      .bank_vec (rd_bank),
      .rd_ptr   (rd_ptr),
      .elem     (rd_chunk[i])
    );
  end

  // ---------------------------------------------------------------- outputs
  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = full[rb];
  assign bus.rd_data  = rd_chunk;
  assign bus.ovf_err  = ovf;
endmodule

// File: tb/tb_vec_chunk_buffer.sv
module tb_vec_chunk_buffer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vec_chunk_buffer_if #(.Chunk(4)) bus ();

  vec_chunk_buffer #(.VecLength(8), .Chunk(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        req;
    logic        prst;
    logic        rel;
    logic        e_wrdy;
    logic        e_rrdy;
    logic        e_ovf;
    logic        cd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic wv, logic [7:0] wd, logic req, logic prst,
                             logic rel, logic e_wrdy, logic e_rrdy, logic e_ovf,
                             logic cd, logic [31:0] e_data);
    vec_t r;
    r.wv = wv; r.wd = wd; r.req = req; r.prst = prst; r.rel = rel;
    r.e_wrdy = e_wrdy; r.e_rrdy = e_rrdy; r.e_ovf = e_ovf;
    r.cd = cd; r.e_data = e_data;
    return r;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, logic wrdy, logic rrdy, logic ovf,
                          logic cd, logic [31:0] data);
    chk1({tag, ".wr_ready"}, bus.wr_ready, wrdy);
    chk1({tag, ".rd_ready"}, bus.rd_ready, rrdy);
    chk1({tag, ".ovf_err"},  bus.ovf_err,  ovf);
    if (cd) chk32({tag, ".rd_data"}, bus.rd_data, data);
  endtask

  // Drive at negedge, let one rising edge happen, then sample 1 time unit later.
  task automatic apply(logic wv, logic [7:0] wd, logic req, logic prst, logic rel);
    bus.wr_valid     = wv;
    bus.wr_data      = wd;
    bus.rd_chunk_req = req;
    bus.rd_ptr_rst   = prst;
    bus.rd_release   = rel;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 0; bus.wr_data = 0; bus.rd_chunk_req = 0;
    bus.rd_ptr_rst = 0; bus.rd_release = 0;
  endtask

  initial begin
    idle_inputs();

    // ---------------------------------------------------------- vector table
    // Fill bank 0 with 1..8.
    for (int k = 1; k <= 8; k++)
      tbl.push_back(v(1, 8'(k), 0, 0, 0, 1, (k == 8), 0,
                      (k == 4 || k == 8), 32'h04030201));
    // Chunk advance, wrap, rewind, rewind beats advance.
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 1, 32'h08070605));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 1, 32'h04030201));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 1, 32'h08070605));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, 1, 32'h04030201));
    tbl.push_back(v(0, 0, 1, 1, 0, 1, 1, 0, 1, 32'h04030201));
    // Fill bank 1 with 9..16, no release: both full, wr_ready drops.
    for (int k = 9; k <= 16; k++)
      tbl.push_back(v(1, 8'(k), 0, 0, 0, (k != 16), 1, 0, 1, 32'h04030201));
    // Offer 17 while full: dropped, sticky overflow.
    tbl.push_back(v(1, 8'd17, 0, 0, 0, 0, 1, 1, 1, 32'h04030201));
    // Release bank 0: read bank 1, space available again.
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h0c0b0a09));
    // Fill bank 0 with 21..28 while reading bank 1 concurrently.
    tbl.push_back(v(1, 8'd21, 1, 0, 0, 1, 1, 1, 1, 32'h100f0e0d));
    for (int k = 22; k <= 27; k++)
      tbl.push_back(v(1, 8'(k), 0, 0, 0, 1, 1, 1, 1, 32'h100f0e0d));
    // Last element and release on the same edge: rd_ready stays, switch banks.
    tbl.push_back(v(1, 8'd28, 0, 0, 1, 1, 1, 1, 1, 32'h18171615));
    // Release bank 0: bank 1 empty now (stale contents still visible).
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h0c0b0a09));
    // Advance honoured without rd_ready; release without rd_ready ignored.
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 0, 1, 1, 32'h100f0e0d));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h100f0e0d));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 1, 32'h0c0b0a09));
    // Fill bank 1 with 31..38 normally after the ignored release.
    for (int k = 31; k <= 38; k++)
      tbl.push_back(v(1, 8'(k), 0, 0, 0, 1, (k == 38), 1, (k == 38), 32'h2221201f));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 1, 1, 32'h26252423));

    // ---------------------------------------------------------- reset state
    #12;
    chk_outs("reset", 1, 0, 0, 1, 32'h0);
    @(negedge clk_in);
    rst_in = 0;

    foreach (tbl[i]) begin
      @(negedge clk_in);
      apply(tbl[i].wv, tbl[i].wd, tbl[i].req, tbl[i].prst, tbl[i].rel);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_wrdy, tbl[i].e_rrdy,
               tbl[i].e_ovf, tbl[i].cd, tbl[i].e_data);
    end

    // ---------------------------------------------------------- async reset
    // Bank 1 full and mid-read; put 5 elements into bank 0, then reset
    // between edges.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      apply(1, 8'(40 + k), 0, 0, 0);
    end
    @(negedge clk_in);
    idle_inputs();
    #1;
    chk_outs("pre_rst", 1, 1, 1, 1, 32'h26252423);
    rst_in = 1;
    #1;
    chk_outs("async_rst", 1, 0, 0, 1, 32'h0);
    @(negedge clk_in);
    rst_in = 0;

    // Fresh vector after reset reads from bank 0 from element 0.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      apply(1, 8'(k), 0, 0, 0);
      chk1($sformatf("refill%0d.rd_ready", k), bus.rd_ready, (k == 8));
    end
    chk32("refill.chunk0", bus.rd_data, 32'h04030201);
    @(negedge clk_in);
    apply(0, 0, 1, 0, 0);
    chk32("refill.chunk1", bus.rd_data, 32'h08070605);
    chk1("refill.ovf_err", bus.ovf_err, 0);
    chk1("refill.wr_ready", bus.wr_ready, 1);

    @(negedge clk_in);
    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the directed sequence is short, so this never fires normally.
  initial begin
    #100000;
    $display("FAIL timeout: got no end want end");
    $fatal(1);
  end
endmodule

// File: doc/vec_chunk_buffer.md
# vec_chunk_buffer

Double-buffered activation vector store that sits between two matrix-vector layers. The write side accepts one signed 8-bit element per cycle from an upstream layer's output stream; the read side serves fixed-width chunks to the downstream layer's chunk-request interface. The read side supports chunk advance, pointer rewind for replaying the vector per output row, and bank release. One bank is read while the other fills, so layers pipeline without stalls.

## Interface
Parameters:
- VecLength, 8, elements per vector; must be a multiple of Chunk.
- Chunk, 4, elements per read chunk (downstream working registers).
- NumChunks, VecLength/Chunk, derived; not overridable.

Ports:
- clk_in  input  1  sole clock; all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- wr_valid  input  1  element present on wr_data this cycle (driven by upstream req_chunk_out).
- wr_data  input  8  signed element.
- wr_ready  output  1  a bank is accepting elements.
- rd_ready  output  1  read bank holds a complete vector (drives downstream in_data_ready).
- rd_data  output  Chunk×8  packed signed chunk at current read pointer; lane i = element rd_ptr*Chunk+i.
- rd_chunk_req  input  1  advance read pointer one chunk.
- rd_ptr_rst  input  1  rewind read pointer to chunk 0.
- rd_release  input  1  downstream finished with read bank; free it.
- ovf_err  output  1  sticky: element offered while wr_ready low.

## Operation
- Storage: two banks, each VecLength×8 bits in flops, zeroed on reset.
- Write side: write bank wb, element counter wcnt (0..VecLength-1). Accepted element (wr_valid & wr_ready) stored at bank[wb][wcnt]. On accepting element VecLength-1: bank marked full, wb toggles, wcnt←0.
- wr_ready = number of full banks < 2.
- wr_valid while wr_ready low: element dropped, no state change, ovf_err←1 (cleared only by reset).
- Read side: read bank rb, chunk pointer rd_ptr (0..NumChunks-1).
- rd_ready = bank rb full.
- rd_data = bank[rb] chunk rd_ptr, combinational from registered state (rb, rd_ptr, storage).
- rd_chunk_req at edge: rd_ptr←rd_ptr+1, wraps NumChunks-1→0. Honoured regardless of rd_ready.
- rd_ptr_rst at edge: rd_ptr←0.
- rd_release with rd_ready high: bank rb marked empty, rb toggles, rd_ptr←0. With rd_ready low: ignored.
- Priority on read pointer: rd_release > rd_ptr_rst > rd_chunk_req.
- Simultaneous write completion and release: full count net unchanged; if both banks involve the same index (only possible when full count was 1 and wb≠rb), both updates apply independently.
- No arithmetic on data; elements pass bit-exact.

## Timing
- Reset values: wr_ready=1, rd_ready=0, rd_data=0, ovf_err=0; wb=rb=0, wcnt=0, rd_ptr=0, both banks empty.
- Reset asserted mid-fill or mid-read: all partial data discarded, outputs return to reset values immediately (asynchronous).
- Write latency: last element accepted at edge N → rd_ready high in cycle after edge N (if that bank is rb); rd_data shows chunk 0 same cycle.
- Chunk advance latency: rd_chunk_req sampled at edge N → rd_data shows next chunk after edge N, so a consumer sampling rd_data one cycle after requesting sees the new chunk.
- Release latency: rd_release at edge N → rd_ready reflects the other bank's status after edge N; if full, rd_data shows its chunk 0 immediately.
- Sustained throughput: one element written per cycle, one chunk advance per cycle, concurrently.
- wr_ready falls in cycle after the edge that completes the second full bank; rises in cycle after the freeing release.

## Test plan
- Reset, write elements 1..8 on consecutive cycles (VecLength=8, Chunk=4) → after 8th edge rd_ready=1, rd_data lanes 0..3 = 1,2,3,4; wr_ready stays 1.
- Pulse rd_chunk_req → rd_data = 5,6,7,8; pulse again → wraps to 1,2,3,4; advance once then rd_ptr_rst → 1,2,3,4; rd_chunk_req and rd_ptr_rst together → 1,2,3,4.
- Write 1..8 then 9..16 with no release → wr_ready low after 16th; offer 17 → ovf_err=1, rd_data still 1,2,3,4; release → rd_data = 9,10,11,12, wr_ready=1.
- Release on the same edge as the last element of bank 1 while bank 0 is read → rd_ready stays 1, rd_data switches to bank 1 chunk 0.
- rd_release with rd_ready=0 → no change to rd_ptr/rb; later fill proceeds normally.
- Assert rst_in after 5 elements written and mid-read of a full bank → outputs at reset values without a clock edge; fresh 8-element write then reads correctly.
